// File: rtl/mem_arb.sv
// mem_arb: shares one 16-bit bus between instruction fetch and exec data.
// Exec has fixed priority over fetch, and a bus cycle is never preempted.
// A single FSM owns the bus. Bus outputs are registered and held while
// the strobe is high.
// Optional feature: define MEM_ARB_UNALIGNED_EN to split odd-address exec
// word accesses into two byte cycles. Without it, such an access is
// performed as an aligned word.
`timescale 1ns/1ps

module mem_arb (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        f_req,
  input  logic [19:0] f_addr,
  output logic [15:0] f_data,
  output logic        f_rdy,
  // exec data port
  input  logic        e_req,
  input  logic [19:0] e_addr,
  input  logic        e_we,
  input  logic        e_byteop,
  input  logic        e_m_io,
  input  logic [15:0] e_wr_data,
  output logic [15:0] e_data,
  output logic        e_rdy,
  // bus master
  output logic        m_cyc,
  output logic        m_stb,
  output logic [18:0] m_adr,
  output logic [1:0]  m_sel,
  output logic        m_we,
  output logic        m_tga,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  input  logic        m_ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC1 = 3'd2,
    EXEC2 = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e      state_reg, state_next;

  // Owner of the transaction in flight (1 = exec, 0 = fetch).
  logic        exec_reg, exec_next;
  // Latched exec attributes needed after the request is accepted.
  logic        byteop_reg, byteop_next;
  logic        odd_reg, odd_next;

  // Registered bus outputs.
  logic [18:0] adr_reg, adr_next;
  logic [1:0]  sel_reg, sel_next;
  logic        we_reg, we_next;
  logic        tga_reg, tga_next;
  logic [15:0] dat_o_reg, dat_o_next;

  // Requester read data, held until that requester's next completion.
  logic [15:0] f_data_reg, f_data_next;
  logic [15:0] e_data_reg, e_data_next;

  // Result of a single-cycle exec read: the selected lane for a byte access,
  // the whole word otherwise.
  logic [15:0] exec1_rd_data;

`ifdef MEM_ARB_UNALIGNED_EN
  // Split-access state: the second-cycle address and write byte are fixed
  // when the request is accepted; the first-cycle read byte is kept until
  // the second ack arrives.
  logic        split_reg, split_next;
  logic [18:0] adr2_reg, adr2_next;
  logic [7:0]  hi_wr_reg, hi_wr_next;
  logic [7:0]  lo_rd_reg, lo_rd_next;
  logic [19:0] e_addr_inc;

  // Address of the second byte, with 20-bit wrap-around.
  assign e_addr_inc = e_addr + 20'd1;
`endif

  // Fetch addresses are word aligned, so the byte-select bit carries no meaning.
  logic unused_f_addr_bit;
  assign unused_f_addr_bit = f_addr[0];

  // Lane selection for a single-cycle exec read.
  always_comb begin
    exec1_rd_data = m_dat_i;
    if (byteop_reg) begin
      exec1_rd_data = {8'h00, (odd_reg ? m_dat_i[15:8] : m_dat_i[7:0])};
    end
  end

  // State register and all datapath registers; reset abandons any bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      exec_reg   <= 1'b0;
      byteop_reg <= 1'b0;
      odd_reg    <= 1'b0;
      adr_reg    <= 19'd0;
      sel_reg    <= 2'b00;
      we_reg     <= 1'b0;
      tga_reg    <= 1'b0;
      dat_o_reg  <= 16'h0000;
      f_data_reg <= 16'h0000;
      e_data_reg <= 16'h0000;
`ifdef MEM_ARB_UNALIGNED_EN
      split_reg  <= 1'b0;
      adr2_reg   <= 19'd0;
      hi_wr_reg  <= 8'h00;
      lo_rd_reg  <= 8'h00;
`endif
    end else begin
      state_reg  <= state_next;
      exec_reg   <= exec_next;
      byteop_reg <= byteop_next;
      odd_reg    <= odd_next;
      adr_reg    <= adr_next;
      sel_reg    <= sel_next;
      we_reg     <= we_next;
      tga_reg    <= tga_next;
      dat_o_reg  <= dat_o_next;
      f_data_reg <= f_data_next;
      e_data_reg <= e_data_next;
`ifdef MEM_ARB_UNALIGNED_EN
      split_reg  <= split_next;
      adr2_reg   <= adr2_next;
      hi_wr_reg  <= hi_wr_next;
      lo_rd_reg  <= lo_rd_next;
`endif
    end
  end

  // Next-state logic: arbitration and request latching in IDLE, ack handling
  // in the strobe states. Everything holds by default.
  always_comb begin
    state_next  = state_reg;
    exec_next   = exec_reg;
    byteop_next = byteop_reg;
    odd_next    = odd_reg;
    adr_next    = adr_reg;
    sel_next    = sel_reg;
    we_next     = we_reg;
    tga_next    = tga_reg;
    dat_o_next  = dat_o_reg;
    f_data_next = f_data_reg;
    e_data_next = e_data_reg;
`ifdef MEM_ARB_UNALIGNED_EN
    split_next  = split_reg;
    adr2_next   = adr2_reg;
    hi_wr_next  = hi_wr_reg;
    lo_rd_next  = lo_rd_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (e_req) begin
          state_next  = EXEC1;
          exec_next   = 1'b1;
          byteop_next = e_byteop;
          odd_next    = e_addr[0];
          adr_next    = e_addr[19:1];
          we_next     = e_we;
          tga_next    = e_m_io;
          if (e_byteop) begin
            // A byte rides on whichever lane matches its address; the write
            // byte is replicated so both lanes carry it.
            sel_next   = e_addr[0] ? 2'b10 : 2'b01;
            dat_o_next = {e_wr_data[7:0], e_wr_data[7:0]};
          end else begin
            sel_next   = 2'b11;
            dat_o_next = e_wr_data;
          end
`ifdef MEM_ARB_UNALIGNED_EN
          split_next = !e_byteop && e_addr[0];
          adr2_next  = e_addr_inc[19:1];
          hi_wr_next = e_wr_data[15:8];
          if (!e_byteop && e_addr[0]) begin
            // First half of a split word: low data byte on the high lane.
            sel_next   = 2'b10;
            dat_o_next = {e_wr_data[7:0], e_wr_data[7:0]};
          end
`endif
        end else if (f_req) begin
          state_next = FETCH;
          exec_next  = 1'b0;
          adr_next   = f_addr[19:1];
          sel_next   = 2'b11;
          we_next    = 1'b0;
          tga_next   = 1'b0;
        end
      end

      FETCH: begin
        if (m_ack) begin
          f_data_next = m_dat_i;
          state_next  = DONE;
        end
      end

      EXEC1: begin
        if (m_ack) begin
          state_next = DONE;
          if (!we_reg) begin
            e_data_next = exec1_rd_data;
          end
`ifdef MEM_ARB_UNALIGNED_EN
          if (split_reg) begin
            // Move on to the second byte; the result is assembled after it.
            state_next  = EXEC2;
            e_data_next = e_data_reg;
            lo_rd_next  = m_dat_i[15:8];
            adr_next    = adr2_reg;
            sel_next    = 2'b01;
            dat_o_next  = {hi_wr_reg, hi_wr_reg};
          end
`endif
        end
      end

      EXEC2: begin
`ifdef MEM_ARB_UNALIGNED_EN
        if (m_ack) begin
          state_next = DONE;
          if (!we_reg) begin
            e_data_next = {m_dat_i[7:0], lo_rd_reg};
          end
        end
`else
        // Never entered in this build; recover to IDLE if it ever is.
        state_next = IDLE;
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobe is a pure decode of the state; rdy pulses are the DONE cycle
  // qualified by the owner, so they can never both be high.
  assign m_stb   = (state_reg == FETCH) || (state_reg == EXEC1) || (state_reg == EXEC2);
  assign m_cyc   = m_stb;
  assign f_rdy   = (state_reg == DONE) && !exec_reg;
  assign e_rdy   = (state_reg == DONE) && exec_reg;

  assign m_adr   = adr_reg;
  assign m_sel   = sel_reg;
  assign m_we    = we_reg;
  assign m_tga   = tga_reg;
  assign m_dat_o = dat_o_reg;
  assign f_data  = f_data_reg;
  assign e_data  = e_data_reg;

endmodule
